speicher_steuerung: RTL and testbench

SPEICHER_STEUERUNG -- requirements
Module: speicher_steuerung

---
 rtl/speicher_steuerung.sv | 132 +++++++++++++
 tb/tb_speicher_steuerung.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/speicher_steuerung.sv
// Memory controller: serialises instruction fetches, data loads and data stores onto one synchronous RAM port.
// Optional address checking is enabled by defining SPEICHER_FEHLER_EN.
module speicher_steuerung #(
   parameter int unsigned ADRESSBREITE = 14,
   parameter int unsigned LESELATENZ   = 1
) (
   input  logic                    Clock,
   input  logic                    Reset,
   input  logic                    LoadBefehlSignal,
   input  logic [31:0]             BefehlAdresse,
   input  logic                    LoadDatenSignal,
   input  logic                    StoreDatenSignal,
   input  logic [31:0]             DatenAdresse,
   input  logic [31:0]             SchreibDaten,
   output logic [31:0]             Befehl,
   output logic                    BefehlGeladen,
   output logic [31:0]             LeseDaten,
   output logic                    DatenGeladen,
   output logic                    DatenGespeichert,
   output logic [ADRESSBREITE-1:0] RAMAdresse,
   output logic [31:0]             RAMSchreibDaten,
   output logic                    RAMSchreibFreigabe,
   input  logic [31:0]             RAMLeseDaten,
   output logic                    Fehler
);

   localparam int unsigned ZAEHLERBREITE = 3;

   typedef enum logic [1:0] {
      BEREIT,
      LESEN,
      SCHREIBEN
   } zustandTyp;

   zustandTyp                 zustand;
   logic [ZAEHLERBREITE-1:0]  zaehler;
   logic                      istBefehl;
   logic [31:0]               anfrageAdresse;
   logic [ADRESSBREITE-1:0]   anfrageWort;
   logic                      anfrageLesen;
   logic                      anfrageFehler;
   logic [31:0]               leseWert;

   // Fetch has priority, so its address wins whenever it is requested
   assign anfrageAdresse = LoadBefehlSignal ? BefehlAdresse : DatenAdresse;
   assign anfrageWort    = anfrageAdresse[ADRESSBREITE+1:2];
   assign anfrageLesen   = LoadBefehlSignal || LoadDatenSignal;

`ifdef SPEICHER_FEHLER_EN
   logic zugriffFehler;
   assign anfrageFehler = (anfrageAdresse[1:0] != 2'b00) ||
                          ((anfrageAdresse >> (ADRESSBREITE + 2)) != 32'd0);
   assign leseWert      = zugriffFehler ? 32'd0 : RAMLeseDaten;
`else
   logic unusedBits;
   assign anfrageFehler = 1'b0;
   assign leseWert      = RAMLeseDaten;
   assign unusedBits    = ^{anfrageAdresse[1:0], anfrageAdresse[31:ADRESSBREITE+2]};
   assign Fehler        = 1'b0;
`endif

   always_ff @(posedge Clock) begin
      if (Reset) begin
         zustand            <= BEREIT;
         zaehler            <= '0;
         istBefehl          <= 1'b0;
         Befehl             <= '0;
         LeseDaten          <= '0;
         BefehlGeladen      <= 1'b0;
         DatenGeladen       <= 1'b0;
         DatenGespeichert   <= 1'b0;
         RAMAdresse         <= '0;
         RAMSchreibDaten    <= '0;
         RAMSchreibFreigabe <= 1'b0;
`ifdef SPEICHER_FEHLER_EN
         zugriffFehler      <= 1'b0;
         Fehler             <= 1'b0;
`endif
      end else begin
         // Acks and the write strobe are single-cycle pulses
         BefehlGeladen      <= 1'b0;
         DatenGeladen       <= 1'b0;
         DatenGespeichert   <= 1'b0;
         RAMSchreibFreigabe <= 1'b0;

         case (zustand)
            BEREIT: begin
               if (anfrageLesen) begin
                  zustand    <= LESEN;
                  zaehler    <= '0;
                  istBefehl  <= LoadBefehlSignal;
                  RAMAdresse <= anfrageWort;
`ifdef SPEICHER_FEHLER_EN
                  zugriffFehler <= anfrageFehler;
                  if (anfrageFehler) Fehler <= 1'b1;
`endif
               end else if (StoreDatenSignal) begin
                  zustand            <= SCHREIBEN;
                  RAMAdresse         <= anfrageWort;
                  RAMSchreibDaten    <= SchreibDaten;
                  RAMSchreibFreigabe <= !anfrageFehler;
                  DatenGespeichert   <= 1'b1;
`ifdef SPEICHER_FEHLER_EN
                  if (anfrageFehler) Fehler <= 1'b1;
`endif
               end
            end

            // RAM data is valid LESELATENZ cycles after the address; capture one edge later
            LESEN: begin
               if (zaehler == ZAEHLERBREITE'(LESELATENZ)) begin
                  zustand <= BEREIT;
                  if (istBefehl) begin
                     Befehl        <= leseWert;
                     BefehlGeladen <= 1'b1;
                  end else begin
                     LeseDaten     <= leseWert;
                     DatenGeladen  <= 1'b1;
                  end
               end else begin
                  zaehler <= zaehler + ZAEHLERBREITE'(1);
               end
            end

            SCHREIBEN: zustand <= BEREIT;

            default: zustand <= BEREIT;
         endcase
      end
   end

endmodule

// File: tb/tb_speicher_steuerung.sv
// Directed bench for speicher_steuerung: one LESELATENZ=1 instance and one LESELATENZ=3 instance,
// each with a behavioural synchronous RAM.
module tb_speicher_steuerung;

   localparam int unsigned AB = 14;

   logic          Clock;
   logic          Reset;
   logic          LoadBefehlSignal;
   logic [31:0]   BefehlAdresse;
   logic          LoadDatenSignal;
   logic          StoreDatenSignal;
   logic [31:0]   DatenAdresse;
   logic [31:0]   SchreibDaten;
   logic [31:0]   Befehl;
   logic          BefehlGeladen;
   logic [31:0]   LeseDaten;
   logic          DatenGeladen;
   logic          DatenGespeichert;
   logic [AB-1:0] RAMAdresse;
   logic [31:0]   RAMSchreibDaten;
   logic          RAMSchreibFreigabe;
   logic [31:0]   RAMLeseDaten;
   logic          Fehler;

   logic          l3Load;
   logic [31:0]   l3Adresse;
   logic [31:0]   l3Befehl;
   logic          l3BefehlGeladen;
   logic [31:0]   l3LeseDaten;
   logic          l3DatenGeladen;
   logic          l3DatenGespeichert;
   logic [AB-1:0] l3RAMAdresse;
   logic [31:0]   l3RAMSchreibDaten;
   logic          l3RAMSchreibFreigabe;
   logic [31:0]   l3RAMLeseDaten;
   logic          l3Fehler;

   int vektoren = 0;
   int fehlvergleiche = 0;
   int schreibZaehler = 0;

   logic [31:0] mem1 [0:(1<<AB)-1];
   logic [31:0] mem3 [0:(1<<AB)-1];
   logic [31:0] p0, p1, p2;

   speicher_steuerung #(.ADRESSBREITE(AB), .LESELATENZ(1)) u1 (
      .Clock(Clock), .Reset(Reset),
      .LoadBefehlSignal(LoadBefehlSignal), .BefehlAdresse(BefehlAdresse),
      .LoadDatenSignal(LoadDatenSignal), .StoreDatenSignal(StoreDatenSignal),
      .DatenAdresse(DatenAdresse), .SchreibDaten(SchreibDaten),
      .Befehl(Befehl), .BefehlGeladen(BefehlGeladen),
      .LeseDaten(LeseDaten), .DatenGeladen(DatenGeladen),
      .DatenGespeichert(DatenGespeichert), .RAMAdresse(RAMAdresse),
      .RAMSchreibDaten(RAMSchreibDaten), .RAMSchreibFreigabe(RAMSchreibFreigabe),
      .RAMLeseDaten(RAMLeseDaten), .Fehler(Fehler)
   );

   speicher_steuerung #(.ADRESSBREITE(AB), .LESELATENZ(3)) u3 (
      .Clock(Clock), .Reset(Reset),
      .LoadBefehlSignal(1'b0), .BefehlAdresse(32'd0),
      .LoadDatenSignal(l3Load), .StoreDatenSignal(1'b0),
      .DatenAdresse(l3Adresse), .SchreibDaten(32'd0),
      .Befehl(l3Befehl), .BefehlGeladen(l3BefehlGeladen),
      .LeseDaten(l3LeseDaten), .DatenGeladen(l3DatenGeladen),
      .DatenGespeichert(l3DatenGespeichert), .RAMAdresse(l3RAMAdresse),
      .RAMSchreibDaten(l3RAMSchreibDaten), .RAMSchreibFreigabe(l3RAMSchreibFreigabe),
      .RAMLeseDaten(l3RAMLeseDaten), .Fehler(l3Fehler)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Synchronous RAMs; contents preset while Reset is high
   always @(posedge Clock) begin
      if (Reset) begin
         mem1[4] <= 32'h1234_5678;
         mem1[5] <= 32'h55AA_55AA;
      end else if (RAMSchreibFreigabe) begin
         mem1[RAMAdresse] <= RAMSchreibDaten;
      end
      if (RAMSchreibFreigabe) schreibZaehler = schreibZaehler + 1;
      RAMLeseDaten <= mem1[RAMAdresse];
   end

   always @(posedge Clock) begin
      if (Reset) mem3[6] <= 32'h0BAD_CAFE;
      else if (l3RAMSchreibFreigabe) mem3[l3RAMAdresse] <= l3RAMSchreibDaten;
      p0 <= mem3[l3RAMAdresse];
      p1 <= p0;
      p2 <= p1;
   end
   assign l3RAMLeseDaten = p2;

   task automatic pruefe(input string tag, input logic [31:0] ist, input logic [31:0] soll);
      vektoren = vektoren + 1;
      assert (ist === soll) else begin
         fehlvergleiche = fehlvergleiche + 1;
         $error("FAIL %s: observed %h expected %h", tag, ist, soll);
      end
   endtask

   task automatic takt(input int n);
      repeat (n) @(posedge Clock);
      #1;
   endtask

   int basis;

   initial begin
      Reset = 1'b1;
      LoadBefehlSignal = 1'b0; BefehlAdresse = '0;
      LoadDatenSignal = 1'b0; StoreDatenSignal = 1'b0;
      DatenAdresse = '0; SchreibDaten = '0;
      l3Load = 1'b0; l3Adresse = '0;
      takt(2);
      pruefe("reset_befehl", Befehl, 32'h0);
      pruefe("reset_lesedaten", LeseDaten, 32'h0);
      pruefe("reset_acks", 32'({BefehlGeladen, DatenGeladen, DatenGespeichert}), 32'h0);
      pruefe("reset_ramadresse", 32'(RAMAdresse), 32'h0);
      pruefe("reset_we", 32'(RAMSchreibFreigabe), 32'h0);
      pruefe("reset_fehler", 32'(Fehler), 32'h0);
      Reset = 1'b0;
      takt(1);

      // Fetch from 0x10; request and address change right after acceptance
      LoadBefehlSignal = 1'b1; BefehlAdresse = 32'h0000_0010;
      takt(1);
      LoadBefehlSignal = 1'b0; BefehlAdresse = 32'h0000_0040;
      pruefe("fetch_ramadresse", 32'(RAMAdresse), 32'h4);
      takt(1);
      pruefe("fetch_ack_early", 32'(BefehlGeladen), 32'h0);
      takt(1);
      pruefe("fetch_ack", 32'(BefehlGeladen), 32'h1);
      pruefe("fetch_befehl", Befehl, 32'h1234_5678);
      takt(1);
      pruefe("fetch_ack_pulse", 32'(BefehlGeladen), 32'h0);
      pruefe("fetch_befehl_hold", Befehl, 32'h1234_5678);

      // Store 0xDEADBEEF to 0x20, then load it back
      basis = schreibZaehler;
      StoreDatenSignal = 1'b1; DatenAdresse = 32'h0000_0020; SchreibDaten = 32'hDEAD_BEEF;
      takt(1);
      StoreDatenSignal = 1'b0; SchreibDaten = 32'h0;
      pruefe("store_we", 32'(RAMSchreibFreigabe), 32'h1);
      pruefe("store_ack", 32'(DatenGespeichert), 32'h1);
      pruefe("store_ramadresse", 32'(RAMAdresse), 32'h8);
      pruefe("store_ramdaten", RAMSchreibDaten, 32'hDEAD_BEEF);
      takt(1);
      pruefe("store_we_off", 32'(RAMSchreibFreigabe), 32'h0);
      pruefe("store_ack_off", 32'(DatenGespeichert), 32'h0);
      pruefe("store_one_write", 32'(schreibZaehler - basis), 32'h1);
      LoadDatenSignal = 1'b1; DatenAdresse = 32'h0000_0020;
      takt(1);
      LoadDatenSignal = 1'b0;
      takt(1);
      pruefe("load_ack_early", 32'(DatenGeladen), 32'h0);
      takt(1);
      pruefe("load_ack", 32'(DatenGeladen), 32'h1);
      pruefe("load_daten", LeseDaten, 32'hDEAD_BEEF);
      takt(1);
      pruefe("load_ack_pulse", 32'(DatenGeladen), 32'h0);

      // Fetch and store raised together: fetch first, store the cycle after BefehlGeladen
      LoadBefehlSignal = 1'b1; BefehlAdresse = 32'h0000_0010;
      StoreDatenSignal = 1'b1; DatenAdresse = 32'h0000_0024; SchreibDaten = 32'hCAFE_F00D;
      takt(1);
      LoadBefehlSignal = 1'b0;
      pruefe("prio_no_store", 32'({RAMSchreibFreigabe, DatenGespeichert}), 32'h0);
      pruefe("prio_fetch_addr", 32'(RAMAdresse), 32'h4);
      takt(2);
      pruefe("prio_fetch_ack", 32'({BefehlGeladen, RAMSchreibFreigabe}), 32'h2);
      takt(1);
      StoreDatenSignal = 1'b0;
      pruefe("prio_store_ack", 32'({BefehlGeladen, DatenGespeichert, RAMSchreibFreigabe}), 32'h3);
      pruefe("prio_store_addr", 32'(RAMAdresse), 32'h9);
      takt(1);

      // Store request held high after its ack is accepted again
      StoreDatenSignal = 1'b1; DatenAdresse = 32'h0000_0030; SchreibDaten = 32'h1111_1111;
      takt(1);
      pruefe("hold_first_ack", 32'(DatenGespeichert), 32'h1);
      DatenAdresse = 32'h0000_0034; SchreibDaten = 32'h2222_2222;
      takt(1);
      pruefe("hold_gap", 32'({DatenGespeichert, RAMSchreibFreigabe}), 32'h0);
      takt(1);
      StoreDatenSignal = 1'b0;
      pruefe("hold_second_ack", 32'(DatenGespeichert), 32'h1);
      pruefe("hold_second_addr", 32'(RAMAdresse), 32'hD);
      pruefe("hold_second_data", RAMSchreibDaten, 32'h2222_2222);
      takt(1);

      // Reset during the LESEN cycle of a load aborts it
      LoadDatenSignal = 1'b1; DatenAdresse = 32'h0000_0014;
      takt(1);
      LoadDatenSignal = 1'b0; Reset = 1'b1;
      takt(1);
      Reset = 1'b0;
      pruefe("abort_lesedaten", LeseDaten, 32'h0);
      pruefe("abort_ramadresse", 32'(RAMAdresse), 32'h0);
      takt(1);
      pruefe("abort_no_ack", 32'(DatenGeladen), 32'h0);
      takt(1);
      pruefe("abort_no_ack_late", 32'(DatenGeladen), 32'h0);
      LoadDatenSignal = 1'b1; DatenAdresse = 32'h0000_0014;
      takt(1);
      LoadDatenSignal = 1'b0;
      takt(2);
      pruefe("after_abort_ack", 32'(DatenGeladen), 32'h1);
      pruefe("after_abort_daten", LeseDaten, 32'h55AA_55AA);

      // Reset wins over a store in the same cycle
      basis = schreibZaehler;
      StoreDatenSignal = 1'b1; DatenAdresse = 32'h0000_0020; SchreibDaten = 32'h9999_9999; Reset = 1'b1;
      takt(1);
      StoreDatenSignal = 1'b0; Reset = 1'b0;
      pruefe("reset_prio", 32'({DatenGespeichert, RAMSchreibFreigabe}), 32'h0);
      takt(1);
      pruefe("reset_prio_writes", 32'(schreibZaehler - basis), 32'h0);

`ifdef SPEICHER_FEHLER_EN
      // Misaligned store: no RAM write, ack still pulses, sticky Fehler
      basis = schreibZaehler;
      StoreDatenSignal = 1'b1; DatenAdresse = 32'h0000_0022; SchreibDaten = 32'h3333_3333;
      takt(1);
      StoreDatenSignal = 1'b0;
      pruefe("err_ack", 32'({DatenGespeichert, RAMSchreibFreigabe}), 32'h2);
      pruefe("err_fehler", 32'(Fehler), 32'h1);
      takt(3);
      pruefe("err_sticky", 32'(Fehler), 32'h1);
      pruefe("err_no_write", 32'(schreibZaehler - basis), 32'h0);
      Reset = 1'b1;
      takt(1);
      Reset = 1'b0;
      pruefe("err_cleared", 32'(Fehler), 32'h0);
`else
      // Without checking, low bits are dropped and high bits wrap
      StoreDatenSignal = 1'b1; DatenAdresse = 32'h0001_0022; SchreibDaten = 32'h3333_3333;
      takt(1);
      StoreDatenSignal = 1'b0;
      pruefe("wrap_we", 32'(RAMSchreibFreigabe), 32'h1);
      pruefe("wrap_addr", 32'(RAMAdresse), 32'h8);
      pruefe("wrap_fehler", 32'(Fehler), 32'h0);
      takt(1);
      LoadBefehlSignal = 1'b1; BefehlAdresse = 32'h0000_0023;
      takt(1);
      LoadBefehlSignal = 1'b0;
      takt(2);
      pruefe("wrap_fetch_ack", 32'(BefehlGeladen), 32'h1);
      pruefe("wrap_fetch", Befehl, 32'h3333_3333);
`endif
      takt(1);

      // LESELATENZ=3 instance: ack exactly 4 edges after acceptance
      l3Load = 1'b1; l3Adresse = 32'h0000_0018;
      takt(1);
      l3Load = 1'b0;
      pruefe("l3_addr", 32'(l3RAMAdresse), 32'h6);
      takt(2);
      pruefe("l3_ack_early2", 32'(l3DatenGeladen), 32'h0);
      takt(1);
      pruefe("l3_ack_early3", 32'(l3DatenGeladen), 32'h0);
      takt(1);
      pruefe("l3_ack", 32'(l3DatenGeladen), 32'h1);
      pruefe("l3_daten", l3LeseDaten, 32'h0BAD_CAFE);
      takt(1);
      pruefe("l3_ack_pulse", 32'(l3DatenGeladen), 32'h0);
      pruefe("l3_idle_outputs", 32'({l3BefehlGeladen, l3DatenGespeichert, l3RAMSchreibFreigabe, l3Fehler}), 32'h0);
      pruefe("l3_befehl", l3Befehl, 32'h0);
      pruefe("l3_schreibdaten", l3RAMSchreibDaten, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vektoren, fehlvergleiche);
      $finish;
   end

endmodule
